ioff_scan_ctrl: RTL

IOFF_SCAN_CTRL -- requirements
Module: ioff_scan_ctrl

---
 rtl/ioff_cfg_pkg.sv | 5 +
 rtl/ioff_scan_shreg.sv | 35 +++
 rtl/ioff_scan_ctrl.sv | 71 +++++++
 3 files changed

// File: rtl/ioff_cfg_pkg.sv
// ioff_cfg_pkg: shared state type and default chain length for the IOFF scan controller
package ioff_cfg_pkg;
  localparam int IOFF_CHAIN_LEN_DEFAULT = 16;
  typedef enum logic [2:0] {IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, FINISH} ioff_scan_state_t;
endpackage

// File: rtl/ioff_scan_shreg.sv
// ioff_scan_shreg: parallel-load shift register with saturating shift counter
module ioff_scan_shreg
  import ioff_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = IOFF_CHAIN_LEN_DEFAULT,
  localparam int CNT_W = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 prog_clk,
  input  logic                 pReset,
  input  logic                 load,
  input  logic                 clr,
  input  logic                 shift,
  input  logic                 si,
  input  logic [CHAIN_LEN-1:0] load_data,
  output logic                 so,
  output logic [CHAIN_LEN-1:0] q,
  output logic [CNT_W-1:0]     count,
  output logic                 count_done
);
  assign so = q[CHAIN_LEN-1];
  assign count_done = count == CNT_W'(CHAIN_LEN);
  // Shifting stops once the count saturates, so the counter can never wrap
  always_ff @(posedge prog_clk)
    if (pReset) begin
      q <= '0;
      count <= '0;
    end else if (load) begin
      q <= load_data;
      count <= '0;
    end else if (shift && !count_done) begin
      q <= {q[CHAIN_LEN-2:0], si};
      count <= count + 1'b1;
    end else if (clr)
      count <= '0;
endmodule

// File: rtl/ioff_scan_ctrl.sv
// ioff_scan_ctrl: IOFF scan-chain load/unload controller
// IOFF_SCAN_CAPTURE_EN adds a CAPTURE cycle and a SHIFT_OUT pass so unload_data holds captured D values.
module ioff_scan_ctrl
  import ioff_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = IOFF_CHAIN_LEN_DEFAULT,
  localparam int CNT_W = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 prog_clk,
  input  logic                 pReset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CHAIN_LEN-1:0] load_data,
  input  logic                 scan_so,
  output logic                 scan_en,
  output logic                 scan_si,
  output logic [CHAIN_LEN-1:0] unload_data,
  output logic                 busy,
  output logic                 done
);
  ioff_scan_state_t state;
  logic [CHAIN_LEN-1:0] q;
  logic [CNT_W-1:0] count;
  logic count_done, so, shifting, last;
  assign shifting = state == SHIFT_IN || state == SHIFT_OUT;
  assign scan_en = shifting;
  assign scan_si = state == SHIFT_IN && so;
  assign busy = state != IDLE;
  // The shift on this edge is the CHAIN_LEN-th one
  assign last = count == CNT_W'(CHAIN_LEN - 1);
  ioff_scan_shreg #(.CHAIN_LEN(CHAIN_LEN)) u_shreg (
    .prog_clk   (prog_clk),
    .pReset     (pReset),
    .load       (state == IDLE && start && !abort),
    .clr        (state == CAPTURE),
    .shift      (shifting && !abort),
    .si         (scan_so),
    .load_data  (load_data),
    .so         (so),
    .q          (q),
    .count      (count),
    .count_done (count_done)
  );
  always_ff @(posedge prog_clk)
    if (pReset) begin
      state <= IDLE;
      unload_data <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort)
        state <= IDLE;
      else
        case (state)
          IDLE: if (start) state <= SHIFT_IN;
`ifdef IOFF_SCAN_CAPTURE_EN
          SHIFT_IN: if (last) state <= CAPTURE;
          CAPTURE: state <= SHIFT_OUT;
          SHIFT_OUT: if (last) state <= FINISH;
`else
          SHIFT_IN: if (last) state <= FINISH;
`endif
          FINISH: begin
            state <= IDLE;
            unload_data <= q;
            done <= 1'b1;
          end
          default: state <= IDLE;
        endcase
    end
endmodule
